// File: rtl/hilo_unit_if.sv
// hilo_unit_if: bundles the HI/LO unit request/response signals.
//   master : pipeline side (drives start/res/MT/read requests, observes HI/LO and status)
//   slave  : hilo_unit side
// Signals:
//   start, res_valid, res[2*WIDTH]        -- mult/div issue and result strobe
//   mthi_we, mtlo_we, mt_data[WIDTH]      -- MTHI/MTLO writes
//   rd_req, rd_sel, rd_data[WIDTH]        -- MFHI/MFLO reads (rd_sel: 1 = HI, 0 = LO)
//   hi_out, lo_out, busy, stall, err      -- state and status
interface hilo_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               res_valid;
  logic [2*WIDTH-1:0] res;
  logic               mthi_we;
  logic               mtlo_we;
  logic [WIDTH-1:0]   mt_data;
  logic               rd_req;
  logic               rd_sel;
  logic [WIDTH-1:0]   hi_out;
  logic [WIDTH-1:0]   lo_out;
  logic [WIDTH-1:0]   rd_data;
  logic               busy;
  logic               stall;
  logic               err;

  modport master (
    output start, res_valid, res, mthi_we, mtlo_we, mt_data, rd_req, rd_sel,
    input  hi_out, lo_out, rd_data, busy, stall, err
  );

  modport slave (
    input  start, res_valid, res, mthi_we, mtlo_we, mt_data, rd_req, rd_sel,
    output hi_out, lo_out, rd_data, busy, stall, err
  );
endinterface

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register pair with a pending-result tracker and timeout.
//   An issued mult/div (start) moves the unit to PEND until the result strobe
//   arrives or TIMEOUT cycles elapse (then err is set, sticky until reset).
//   MTHI/MTLO writes are taken only in IDLE; reads/writes during PEND raise stall.
// Ports:
//   clk   -- clock, rising edge
//   reset -- asynchronous, active-high
//   bus   -- hilo_unit_if.slave (see interface for signal list)
// Parameters:
//   WIDTH   -- HI/LO width; result bus is 2*WIDTH
//   TIMEOUT -- max PEND cycles before abort, 1..255
// Configuration:
//   HILO_BYPASS_EN -- when defined, rd_data forwards same-cycle write data.
module hilo_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 40
) (
  input logic        clk,
  input logic        reset,
  hilo_unit_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StPend} state_e;

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  state_e           state_q;
  logic [7:0]       cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // A result strobe in IDLE is deliberately ignored.
          if (bus.mthi_we) hi_q <= bus.mt_data;
          if (bus.mtlo_we) lo_q <= bus.mt_data;
          if (bus.start) begin
            state_q <= StPend;
            cnt_q   <= TimeoutVal;
          end
        end
        StPend: begin
          if (bus.res_valid) begin
            hi_q <= bus.res[2*WIDTH-1:WIDTH];
            lo_q <= bus.res[WIDTH-1:0];
            if (bus.start) begin
              // Back-to-back issue: stay pending for the new operation.
              cnt_q <= TimeoutVal;
            end else begin
              state_q <= StIdle;
              cnt_q   <= 8'd0;
            end
          end else if (cnt_q <= 8'd1) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            err_q   <= 1'b1;
          end else begin
            // start without a result is ignored: no reload here.
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  logic busy;
  assign busy = (state_q == StPend);

  always_comb begin
    bus.rd_data = bus.rd_sel ? hi_q : lo_q;
`ifdef HILO_BYPASS_EN
    if (busy && bus.res_valid) begin
      bus.rd_data = bus.rd_sel ? bus.res[2*WIDTH-1:WIDTH] : bus.res[WIDTH-1:0];
    end else if (!busy && bus.rd_sel && bus.mthi_we) begin
      bus.rd_data = bus.mt_data;
    end else if (!busy && !bus.rd_sel && bus.mtlo_we) begin
      bus.rd_data = bus.mt_data;
    end
`endif
  end

  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
  assign bus.busy   = busy;
  assign bus.stall  = busy & (bus.rd_req | bus.mthi_we | bus.mtlo_we);
  assign bus.err    = err_q;

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  hilo_unit_if #(.WIDTH(32)) bus ();
  hilo_unit_if #(.WIDTH(32)) bus_t ();

  hilo_unit #(.WIDTH(32), .TIMEOUT(40)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  hilo_unit #(.WIDTH(32), .TIMEOUT(4)) dut_t (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.start = 0; bus.res_valid = 0; bus.res = '0; bus.mthi_we = 0; bus.mtlo_we = 0;
    bus.mt_data = '0; bus.rd_req = 0; bus.rd_sel = 0;
    bus_t.start = 0; bus_t.res_valid = 0; bus_t.res = '0; bus_t.mthi_we = 0;
    bus_t.mtlo_we = 0; bus_t.mt_data = '0; bus_t.rd_req = 0; bus_t.rd_sel = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.rd_req = 1; bus.rd_sel = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
      $display("FAIL reset_held_status busy=%b stall=%b required 0 0", bus.busy, bus.stall);
      errors++;
    end
    reset = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (bus.rd_data !== 32'h0) begin
      $display("FAIL reset_rd_data got=%h required=0", bus.rd_data); errors++;
    end
    checks++;
    if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin
      $display("FAIL reset_hilo hi=%h lo=%h required 0 0", bus.hi_out, bus.lo_out); errors++;
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.stall !== 1'b0) begin
      $display("FAIL reset_status busy=%b err=%b stall=%b required 0 0 0",
               bus.busy, bus.err, bus.stall);
      errors++;
    end
    bus.rd_req = 0;
  endtask

  task automatic test_mt_write();
    logic [31:0] exp_rd;
    @(negedge clk);
    bus.mthi_we = 1; bus.mt_data = 32'h12345678; bus.rd_req = 1; bus.rd_sel = 1;
`ifdef HILO_BYPASS_EN
    exp_rd = 32'h12345678;
`else
    exp_rd = 32'h0;
`endif
    #1;
    checks++;
    if (bus.rd_data !== exp_rd) begin
      $display("FAIL mthi_same_cycle_read got=%h required=%h", bus.rd_data, exp_rd); errors++;
    end
    @(negedge clk);
    bus.mthi_we = 0; bus.rd_req = 0; #1;
    checks++;
    if (bus.hi_out !== 32'h12345678 || bus.lo_out !== 32'h0) begin
      $display("FAIL mthi_write hi=%h lo=%h required 12345678 00000000", bus.hi_out, bus.lo_out);
      errors++;
    end
    // Both write enables at once load both halves.
    bus.mthi_we = 1; bus.mtlo_we = 1; bus.mt_data = 32'hCAFEBABE;
    @(negedge clk);
    bus.mthi_we = 0; bus.mtlo_we = 0;
    bus.rd_req = 1; bus.rd_sel = 0; #1;
    checks++;
    if (bus.hi_out !== 32'hCAFEBABE || bus.lo_out !== 32'hCAFEBABE) begin
      $display("FAIL mt_both hi=%h lo=%h required cafebabe cafebabe", bus.hi_out, bus.lo_out);
      errors++;
    end
    checks++;
    if (bus.rd_data !== 32'hCAFEBABE || bus.stall !== 1'b0) begin
      $display("FAIL mflo_read rd=%h stall=%b required cafebabe 0", bus.rd_data, bus.stall);
      errors++;
    end
    bus.rd_req = 0;
  endtask

  task automatic test_mult();
    int nbusy;
    nbusy = 0;
    @(negedge clk);
    bus.start = 1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus.start     = 0;
      bus.res_valid = (i == 5);
      bus.res       = 64'hAAAA0000_00005555;
      bus.rd_req    = (i == 2);
      bus.mthi_we   = (i == 3);
      bus.mt_data   = 32'hFFFFFFFF;
      #1;
      if (bus.busy === 1'b1) nbusy++;
      if (i == 2 || i == 3) begin
        checks++;
        if (bus.stall !== 1'b1) begin
          $display("FAIL pend_stall cycle=%0d got=%b required=1", i, bus.stall); errors++;
        end
      end
      if (i == 4) begin
        checks++;
        if (bus.hi_out !== 32'hCAFEBABE) begin
          $display("FAIL pend_mthi_blocked hi=%h required=cafebabe", bus.hi_out); errors++;
        end
      end
    end
    checks++;
    if (nbusy != 5) begin
      $display("FAIL mult_busy_cycles got=%0d required=5", nbusy); errors++;
    end
    @(negedge clk);
    bus.res_valid = 0; bus.rd_req = 0; bus.mthi_we = 0; #1;
    checks++;
    if (bus.hi_out !== 32'hAAAA0000 || bus.lo_out !== 32'h00005555 || bus.busy !== 1'b0) begin
      $display("FAIL mult_result hi=%h lo=%h busy=%b required aaaa0000 00005555 0",
               bus.hi_out, bus.lo_out, bus.busy);
      errors++;
    end
    // Result strobe in IDLE must be dropped.
    bus.res_valid = 1; bus.res = 64'h11112222_33334444;
    @(negedge clk);
    bus.res_valid = 0; bus.rd_req = 1; bus.rd_sel = 1; #1;
    checks++;
    if (bus.hi_out !== 32'hAAAA0000 || bus.lo_out !== 32'h00005555) begin
      $display("FAIL idle_res_ignored hi=%h lo=%h required aaaa0000 00005555",
               bus.hi_out, bus.lo_out);
      errors++;
    end
    checks++;
    if (bus.rd_data !== 32'hAAAA0000 || bus.stall !== 1'b0) begin
      $display("FAIL mfhi_read rd=%h stall=%b required aaaa0000 0", bus.rd_data, bus.stall);
      errors++;
    end
    bus.rd_req = 0;
  endtask

  task automatic test_timeout();
    int nbusy;
    @(negedge clk);
    bus_t.mthi_we = 1; bus_t.mtlo_we = 1; bus_t.mt_data = 32'h11111111;
    bus_t.start = 1;
    @(negedge clk);
    bus_t.mthi_we = 0; bus_t.mtlo_we = 0; bus_t.start = 0;
    nbusy = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus_t.busy === 1'b1) nbusy++;
      bus_t.start = (i == 1);  // start during PEND must not reload the counter
      @(negedge clk);
    end
    bus_t.start = 0;
    #1;
    checks++;
    if (nbusy != 4) begin
      $display("FAIL timeout_busy_cycles got=%0d required=4", nbusy); errors++;
    end
    checks++;
    if (bus_t.err !== 1'b1 || bus_t.busy !== 1'b0) begin
      $display("FAIL timeout_err err=%b busy=%b required 1 0", bus_t.err, bus_t.busy); errors++;
    end
    checks++;
    if (bus_t.hi_out !== 32'h11111111 || bus_t.lo_out !== 32'h11111111) begin
      $display("FAIL timeout_hilo hi=%h lo=%h required 11111111 11111111",
               bus_t.hi_out, bus_t.lo_out);
      errors++;
    end
    bus_t.res_valid = 1; bus_t.res = 64'hDEADBEEF_DEADBEEF;
    @(negedge clk);
    bus_t.res_valid = 0;
    @(negedge clk); #1;
    checks++;
    if (bus_t.hi_out !== 32'h11111111 || bus_t.err !== 1'b1) begin
      $display("FAIL late_res_ignored hi=%h err=%b required 11111111 1", bus_t.hi_out, bus_t.err);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    int nbusy;
    @(negedge clk);
    bus_t.start = 1;
    @(negedge clk);
    bus_t.start = 0;
    @(negedge clk);
    @(negedge clk);
    bus_t.start = 1; bus_t.res_valid = 1; bus_t.res = 64'h01234567_89ABCDEF;
    @(negedge clk);
    bus_t.start = 0; bus_t.res_valid = 0; #1;
    checks++;
    if (bus_t.hi_out !== 32'h01234567 || bus_t.lo_out !== 32'h89ABCDEF) begin
      $display("FAIL b2b_result hi=%h lo=%h required 01234567 89abcdef",
               bus_t.hi_out, bus_t.lo_out);
      errors++;
    end
    nbusy = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus_t.busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    // Reload to TIMEOUT=4 gives four further PEND cycles.
    checks++;
    if (nbusy != 4) begin
      $display("FAIL b2b_reload busy_cycles=%0d required=4", nbusy); errors++;
    end
  endtask

  task automatic test_reset_pend();
    @(negedge clk);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    @(negedge clk);
    bus.res_valid = 1; bus.res = 64'h55555555_66666666; bus.rd_req = 1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.hi_out !== 32'h0 ||
        bus.lo_out !== 32'h0) begin
      $display("FAIL async_reset busy=%b stall=%b hi=%h lo=%h required 0 0 0 0",
               bus.busy, bus.stall, bus.hi_out, bus.lo_out);
      errors++;
    end
    @(negedge clk);
    reset = 1'b0; bus.res_valid = 0; bus.rd_req = 0;
    @(negedge clk); #1;
    checks++;
    if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0 || bus.busy !== 1'b0 ||
        bus.err !== 1'b0) begin
      $display("FAIL reset_pend_after hi=%h lo=%h busy=%b err=%b required 0 0 0 0",
               bus.hi_out, bus.lo_out, bus.busy, bus.err);
      errors++;
    end
    checks++;
    if (bus_t.err !== 1'b0) begin
      $display("FAIL err_cleared_by_reset got=%b required=0", bus_t.err); errors++;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_mt_write();
    test_mult();
    test_timeout();
    test_back_to_back();
    test_reset_pend();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter WIDTH, default 32: width of HI and LO registers; result bus is 2*WIDTH.
REQ-002 Parameter TIMEOUT, default 40: maximum PEND cycles before abort; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  mult/div issued; the unit expects a result.
REQ-006 res_valid  input  1  result strobe from multiplier/divider.
REQ-007 res  input  2*WIDTH  result: upper half goes to HI, lower half to LO.
REQ-008 mthi_we  input  1  MTHI write request.
REQ-009 mtlo_we  input  1  MTLO write request.
REQ-010 mt_data  input  WIDTH  MTHI/MTLO write data.
REQ-011 rd_req  input  1  MFHI/MFLO read request.
REQ-012 rd_sel  input  1  read select: 1 = HI, 0 = LO.
REQ-013 hi_out  output  WIDTH  registered HI.
REQ-014 lo_out  output  WIDTH  registered LO.
REQ-015 rd_data  output  WIDTH  read data, combinational.
REQ-016 busy  output  1  high while state is PEND.
REQ-017 stall  output  1  pipeline hold request, combinational.
REQ-018 err  output  1  sticky timeout flag.

Function
REQ-019 States: IDLE and PEND; busy SHALL equal (state == PEND).
REQ-020 IDLE + start: go to PEND, load counter with TIMEOUT.
REQ-021 IDLE + res_valid: ignore (no HI/LO write).
REQ-022 PEND + res_valid: HI <= res[2W-1:W], LO <= res[W-1:0] at that edge; no start: return to IDLE.
REQ-023 PEND + res_valid + start, same cycle: write HI/LO, stay in PEND, reload counter with TIMEOUT.
REQ-024 PEND + start, no res_valid: ignore start; counter not reloaded.
REQ-025 PEND, no res_valid: counter decrements each cycle.
REQ-026 Counter reaches 1 without res_valid: next edge goes to IDLE, sets err; HI/LO unchanged.
REQ-027 IDLE, MT writes: mthi_we writes HI <= mt_data; mtlo_we writes LO <= mt_data; both high writes both.
REQ-028 IDLE + MT write + start, same cycle: perform the MT write and also enter PEND.
REQ-029 PEND, MT writes: not performed; stall asserted.
REQ-030 stall = busy AND (rd_req OR mthi_we OR mtlo_we); stall is never asserted in IDLE.
REQ-031 rd_data = HI when rd_sel = 1, else LO; subject to REQ-039 bypass.
REQ-032 rd_data is don't-care when rd_req = 0; the bench checks it only when rd_req = 1 and stall = 0.
REQ-033 hi_out and lo_out always show registered HI/LO with one-cycle latency after a write.

Reset
REQ-034 reset high, asynchronous: state = IDLE, counter = 0, HI = 0, LO = 0, err = 0.
REQ-035 Reset mid-PEND: abort immediately; a res_valid coinciding with reset is discarded.
REQ-036 Output values under reset: busy = 0, stall = 0, hi_out = 0, lo_out = 0.
REQ-037 err is cleared only by reset.

Configuration
REQ-038 Macro HILO_BYPASS_EN selects same-cycle forwarding.
REQ-039 Defined, rd_data forwards same-cycle write data: PEND with res_valid forwards the matching half of res; IDLE with mthi_we (rd_sel = 1) or mtlo_we (rd_sel = 0) forwards mt_data.
REQ-040 Undefined: rd_data is registered HI/LO only; a read in the same cycle as a write returns the old value.

Verification
REQ-041 Reset, then rd_req=1, rd_sel=1 -> rd_data=0, hi_out=0, lo_out=0, busy=0, err=0.
REQ-042 IDLE, mthi_we=1 with mt_data=0x12345678, WIDTH=32 -> next cycle hi_out=0x12345678, lo_out unchanged; with HILO_BYPASS_EN, same-cycle read with rd_sel=1 returns 0x12345678.
REQ-043 start, then res_valid 5 cycles later with res=0xAAAA0000_00005555 -> busy high 5 cycles; during PEND, rd_req gives stall=1; afterwards hi_out=0xAAAA0000, lo_out=0x00005555, busy=0.
REQ-044 TIMEOUT=4, start, no res_valid -> busy high exactly 4 cycles, then IDLE with err=1, HI/LO unchanged; a later res_valid is ignored.
REQ-045 PEND, res_valid and start same cycle -> HI/LO written, busy stays 1, counter reloaded to TIMEOUT.
REQ-046 PEND, assert reset for 1 cycle together with res_valid -> HI=0, LO=0, busy=0, err=0.
